network_run_requester: RTL and testbench
========================================

// Module: network_run_requester
// PURPOSE
//  Issuing side of the network run interface: accepts one pixel vector per host request,
//  drives start/pixels into run_network, waits the fixed run length, then samples the
//  class code and balance and returns them to the host over a valid/ready response port.
//  Sits between the JTAG host logic and run_network; also keeps saturating pos/neg tallies.
// PARAMETERS
//  WIDTH        8   weight width of the network (must match run_network)
//  HEIGHT       7   pixel/input count of the network (must match run_network)
//  START_CYCLES 1   cycles net_start is held high per run (>=1)
//  SETTLE       2   extra cycles waited after the nominal run length before sampling
//  CNT_W        16  width of the pos/neg result tallies
//  derived: RUN_CYCLES = HEIGHT*2**(WIDTH+2) (7168 default); BAL_W = $clog2(HEIGHT*2**WIDTH) (11)
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous, active-high reset
//  req_valid       in   1       host offers a pixel vector
//  req_ready       out  1       high only in IDLE
//  req_pixels      in   HEIGHT  pixel vector, captured on req handshake
//  rsp_valid       out  1       result available
//  rsp_ready       in   1       host consumes result
//  rsp_class       out  2       01 pos, 10 neg, 00 on error
//  rsp_balance     out  BAL_W   sampled network balance
//  rsp_error       out  1       sampled code was 00 or 11
//  net_start       out  1       start to run_network (active high)
//  net_pixels      out  HEIGHT  pixels to run_network, held stable from capture to next capture
//  net_neuron_out  in   2       class code from run_network
//  net_balance     in   BAL_W   balance from run_network
//  clr_counts      in   1       zero both tallies (sync)
//  busy            out  1       high in every state except IDLE
//  pos_count       out  CNT_W   saturating count of 01 results delivered
//  neg_count       out  CNT_W   saturating count of 10 results delivered
// BEHAVIOUR
//  - Reset: state IDLE; net_start=0, net_pixels=0, rsp_valid=0, rsp_class=0, rsp_balance=0,
//    rsp_error=0, busy=0, pos_count=neg_count=0, run counter=0. All outputs registered.
//  - FSM: IDLE -> START on req_valid&req_ready (capture req_pixels into net_pixels).
//    START: net_start=1 for exactly START_CYCLES cycles -> RUN.
//    RUN: net_start=0; counter counts RUN_CYCLES+SETTLE cycles -> SAMPLE.
//    SAMPLE (1 cycle): register net_neuron_out/net_balance into rsp_*; code 00/11 -> rsp_error=1,
//    rsp_class=00 -> RESP. RESP: rsp_valid=1, rsp_* stable until rsp_ready -> IDLE.
//  - Latency: handshake at edge k -> rsp_valid first high after edge k+START_CYCLES+RUN_CYCLES+SETTLE+1.
//  - rsp_valid&rsp_ready same cycle rsp_valid rises: accepted, IDLE next cycle; req_ready
//    stays low that cycle (no request overlap with response).
//  - req_valid outside IDLE is ignored, never queued; req_pixels changes after capture have no effect.
//  - Tallies update on rsp handshake only (not on error); saturate at 2**CNT_W-1.
//    clr_counts wins over a simultaneous increment.
//  - rst mid-run: net_start drops next cycle, in-flight result discarded, no rsp_valid.
//  - Counter width $clog2(RUN_CYCLES+SETTLE+1); no wrap before terminal count.
// STRUCTURE
//  - network_pkg: run_cycles(WIDTH,HEIGHT) function, bal_w function, class-code localparams
//    (CLS_UNKNOWN=2'b00, CLS_POS=2'b01, CLS_NEG=2'b10), requester state enum.
//  - Sub-module run_timer: loadable down-counter with terminal-count pulse, used for START and RUN.
// TESTING (WIDTH=2, HEIGHT=2 -> RUN_CYCLES=32, BAL_W=3, with real run_network as DUT load)
//  - req_pixels=2'b11, weights above threshold -> one 1-cycle net_start, rsp_valid at cycle 36 after
//    handshake (START_CYCLES=1, SETTLE=2), rsp_class=01, rsp_error=0, pos_count=1.
//  - req_pixels=2'b00 -> rsp_class=10, neg_count=1, pos_count unchanged.
//  - stub net_neuron_out=2'b11 at sample -> rsp_error=1, rsp_class=00, tallies unchanged.
//  - rsp_ready held low 20 cycles -> rsp_* stable, req_ready=0, second req_valid ignored.
//  - rst asserted at cycle 10 of RUN -> next cycle busy=0, net_start=0, rsp_valid never rises.
//  - CNT_W=2, four pos results -> pos_count saturates at 3; clr_counts with handshake -> 0.

Source files
------------

// File: rtl/network_pkg.sv
// ---------------------------------------------------------------------------
// network_pkg
// Shared definitions for the network run requester:
//   - run_cycles(): nominal run length of run_network for a given geometry
//   - bal_w():      width of the run_network balance output
//   - max_int():    helper for sizing counters
//   - class-code constants returned by run_network
//   - req_state_e:  requester FSM state encoding
// ---------------------------------------------------------------------------
package network_pkg;

    localparam logic [1:0] CLS_UNKNOWN = 2'b00;
    localparam logic [1:0] CLS_POS     = 2'b01;
    localparam logic [1:0] CLS_NEG     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_SAMPLE,
        ST_RESP
    } req_state_e;

    // run_network needs HEIGHT * 2**(WIDTH+2) cycles to produce its class code.
    function automatic int run_cycles(input int width, input int height);
        return height * (1 << (width + 2));
    endfunction

    // Balance spans the full signed range of HEIGHT inputs of WIDTH-bit weights.
    function automatic int bal_w(input int width, input int height);
        return $clog2(height * (1 << width));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/network_run_requester_run_timer.sv
// ---------------------------------------------------------------------------
// run_timer
// Loadable down-counter. A load sets the count; the counter then decrements
// once per cycle down to zero and stays there. tc is high during the last
// counted cycle (count == 1), so loading N gives a tc exactly N cycles after
// the load edge, which lets the owner change state on the very next edge.
//
// Ports:
//   clk       in   1    clock
//   rst       in   1    synchronous active-high reset (count -> 0)
//   load      in   1    load load_val into the counter
//   load_val  in   TW   cycle count to time (>= 1)
//   tc        out  1    terminal-count pulse
// ---------------------------------------------------------------------------
module run_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          tc
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TW'(1));

endmodule

// File: rtl/network_run_requester.sv
// ---------------------------------------------------------------------------
// network_run_requester
// Issuing side of the run_network interface. Accepts one pixel vector per
// host request, pulses net_start for START_CYCLES cycles, waits the fixed run
// length plus SETTLE cycles, samples the class code and balance, and offers
// them on a valid/ready response port. Also keeps saturating tallies of
// positive and negative results delivered to the host.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_pixels        pixel vector captured on the request handshake
//   rsp_valid/ready   response handshake
//   rsp_class         01 pos, 10 neg, 00 on error
//   rsp_balance       sampled network balance
//   rsp_error         sampled code was 00 or 11
//   net_start         start strobe to run_network
//   net_pixels        pixels to run_network, held from capture to capture
//   net_neuron_out    class code from run_network
//   net_balance       balance from run_network
//   clr_counts        zero both tallies (wins over an increment)
//   busy              high in every state except IDLE
//   pos_count         saturating count of delivered 01 results
//   neg_count         saturating count of delivered 10 results
// ---------------------------------------------------------------------------
module network_run_requester
    import network_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int HEIGHT       = 7,
    parameter int START_CYCLES = 1,
    parameter int SETTLE       = 2,
    parameter int CNT_W        = 16,
    parameter int BAL_W        = bal_w(WIDTH, HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [HEIGHT-1:0] req_pixels,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_class,
    output logic [BAL_W-1:0]  rsp_balance,
    output logic              rsp_error,
    output logic              net_start,
    output logic [HEIGHT-1:0] net_pixels,
    input  logic [1:0]        net_neuron_out,
    input  logic [BAL_W-1:0]  net_balance,
    input  logic              clr_counts,
    output logic              busy,
    output logic [CNT_W-1:0]  pos_count,
    output logic [CNT_W-1:0]  neg_count
);

    localparam int RUN_CYCLES = run_cycles(WIDTH, HEIGHT);
    localparam int RUN_LEN    = RUN_CYCLES + SETTLE;
    localparam int TMR_W      = $clog2(max_int(START_CYCLES, RUN_LEN) + 1);

    localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CYCLES);
    localparam logic [TMR_W-1:0] RUN_LOAD   = TMR_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    req_state_e          state_q,       state_d;
    logic                req_ready_q,   req_ready_d;
    logic                busy_q,        busy_d;
    logic                net_start_q,   net_start_d;
    logic [HEIGHT-1:0]   net_pixels_q,  net_pixels_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [1:0]          rsp_class_q,   rsp_class_d;
    logic [BAL_W-1:0]    rsp_balance_q, rsp_balance_d;
    logic                rsp_error_q,   rsp_error_d;
    logic [CNT_W-1:0]    pos_count_q,   pos_count_d;
    logic [CNT_W-1:0]    neg_count_q,   neg_count_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_tc;
    logic                rsp_accept;

    // One timer serves both the START pulse and the RUN wait.
    run_timer #(
        .TW (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tc       (tmr_tc)
    );

    assign rsp_accept = rsp_valid_q && rsp_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        net_start_d   = net_start_q;
        net_pixels_d  = net_pixels_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_class_d   = rsp_class_q;
        rsp_balance_d = rsp_balance_q;
        rsp_error_d   = rsp_error_q;
        pos_count_d   = pos_count_q;
        neg_count_d   = neg_count_q;
        tmr_load      = 1'b0;
        tmr_load_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d      = ST_START;
                    net_pixels_d = req_pixels;
                    net_start_d  = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = START_LOAD;
                end
            end
            ST_START: begin
                if (tmr_tc) begin
                    state_d      = ST_RUN;
                    net_start_d  = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = RUN_LOAD;
                end
            end
            ST_RUN: begin
                if (tmr_tc) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                rsp_balance_d = net_balance;
                rsp_valid_d   = 1'b1;
                state_d       = ST_RESP;
                if (net_neuron_out == CLS_POS || net_neuron_out == CLS_NEG) begin
                    rsp_class_d = net_neuron_out;
                    rsp_error_d = 1'b0;
                end else begin
                    rsp_class_d = CLS_UNKNOWN;
                    rsp_error_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready/busy are registered copies of the next state, so req_ready
        // cannot rise in the cycle a response is being accepted.
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);

        if (clr_counts) begin
            pos_count_d = '0;
            neg_count_d = '0;
        end else if (rsp_accept && !rsp_error_q) begin
            if (rsp_class_q == CLS_POS && pos_count_q != CNT_MAX) begin
                pos_count_d = pos_count_q + CNT_W'(1);
            end
            if (rsp_class_q == CLS_NEG && neg_count_q != CNT_MAX) begin
                neg_count_d = neg_count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: the reset puts every register into a defined state, so a reset in
    // mid-run drops net_start and discards the in-flight result immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            net_start_q   <= 1'b0;
            net_pixels_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_class_q   <= CLS_UNKNOWN;
            rsp_balance_q <= '0;
            rsp_error_q   <= 1'b0;
            pos_count_q   <= '0;
            neg_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            net_start_q   <= net_start_d;
            net_pixels_q  <= net_pixels_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_class_q   <= rsp_class_d;
            rsp_balance_q <= rsp_balance_d;
            rsp_error_q   <= rsp_error_d;
            pos_count_q   <= pos_count_d;
            neg_count_q   <= neg_count_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign net_start   = net_start_q;
    assign net_pixels  = net_pixels_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_class   = rsp_class_q;
    assign rsp_balance = rsp_balance_q;
    assign rsp_error   = rsp_error_q;
    assign pos_count   = pos_count_q;
    assign neg_count   = neg_count_q;

endmodule

// File: tb/tb_network_run_requester.sv
// ---------------------------------------------------------------------------
// tb_network_run_requester
// Bench for network_run_requester with WIDTH=2, HEIGHT=2 (RUN_CYCLES=32,
// BAL_W=3), START_CYCLES=1, SETTLE=2, CNT_W=2. The bench stands in for
// run_network: it presents the intended class code/balance only in the one
// cycle the result must be sampled (35 cycles after the request handshake
// edge) and the inverted values at all other times.
// ---------------------------------------------------------------------------
module tb_network_run_requester;

    localparam int WIDTH        = 2;
    localparam int HEIGHT       = 2;
    localparam int START_CYCLES = 1;
    localparam int SETTLE       = 2;
    localparam int CNT_W        = 2;
    localparam int BAL_W        = 3;
    localparam int RUN_CYCLES   = HEIGHT * (2 ** (WIDTH + 2));
    localparam int EXP_LAT      = START_CYCLES + RUN_CYCLES + SETTLE + 1;
    localparam int SAMPLE_AT    = EXP_LAT - 1;
    localparam int CNT_MAX      = (2 ** CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [HEIGHT-1:0] req_pixels;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_class;
    logic [BAL_W-1:0]  rsp_balance;
    logic              rsp_error;
    logic              net_start;
    logic [HEIGHT-1:0] net_pixels;
    logic [1:0]        net_neuron_out;
    logic [BAL_W-1:0]  net_balance;
    logic              clr_counts;
    logic              busy;
    logic [CNT_W-1:0]  pos_count;
    logic [CNT_W-1:0]  neg_count;

    int checks = 0;
    int errors = 0;

    // Reference tallies.
    int m_pos = 0;
    int m_neg = 0;

    network_run_requester #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .START_CYCLES (START_CYCLES),
        .SETTLE       (SETTLE),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pixels     (req_pixels),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_class      (rsp_class),
        .rsp_balance    (rsp_balance),
        .rsp_error      (rsp_error),
        .net_start      (net_start),
        .net_pixels     (net_pixels),
        .net_neuron_out (net_neuron_out),
        .net_balance    (net_balance),
        .clr_counts     (clr_counts),
        .busy           (busy),
        .pos_count      (pos_count),
        .neg_count      (neg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_class(input logic [1:0] code);
        return (code == 2'b01 || code == 2'b10) ? code : 2'b00;
    endfunction

    function automatic logic exp_error(input logic [1:0] code);
        return !(code == 2'b01 || code == 2'b10);
    endfunction

    task automatic model_accept(input logic [1:0] code, input bit clr);
        if (clr) begin
            m_pos = 0;
            m_neg = 0;
        end else if (code == 2'b01) begin
            m_pos = (m_pos < CNT_MAX) ? m_pos + 1 : CNT_MAX;
        end else if (code == 2'b10) begin
            m_neg = (m_neg < CNT_MAX) ? m_neg + 1 : CNT_MAX;
        end
    endtask

    // ---------------- stimulus helper ----------------
    // Starts at a falling edge with the DUT idle. Performs one request, plays
    // the network, waits (bounded) for rsp_valid, holds rsp_ready low for
    // `hold` cycles (optionally poking a second request), then accepts.
    // Returns to the caller at the falling edge after the accepting edge.
    task automatic run_txn(
        input  logic [HEIGHT-1:0] pix,
        input  logic [1:0]        code,
        input  logic [BAL_W-1:0]  bal,
        input  int                hold,
        input  bit                clr,
        input  bit                poke,
        output int                lat,
        output int                starts,
        output int                pix_err,
        output int                stab_err,
        output logic [1:0]        o_cls,
        output logic [BAL_W-1:0]  o_bal,
        output logic              o_err,
        output logic              o_rdy_at_rise,
        output bit                tmo
    );
        net_neuron_out = ~code;
        net_balance    = ~bal;
        req_valid      = 1'b1;
        req_pixels     = pix;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_pixels = ~pix;
        lat      = 0;
        starts   = net_start ? 1 : 0;
        pix_err  = (net_pixels !== pix) ? 1 : 0;
        stab_err = 0;
        tmo      = 1'b1;
        for (int i = 0; i < 200; i++) begin
            net_neuron_out = (lat == SAMPLE_AT) ? code : ~code;
            net_balance    = (lat == SAMPLE_AT) ? bal  : ~bal;
            @(negedge clk);
            lat++;
            if (net_start) starts++;
            if (net_pixels !== pix) pix_err++;
            if (rsp_valid) begin
                tmo = 1'b0;
                break;
            end
        end
        o_cls = rsp_class;
        o_bal = rsp_balance;
        o_err = rsp_error;
        o_rdy_at_rise = req_ready;
        net_neuron_out = ~code;
        net_balance    = ~bal;
        if (!tmo) begin
            for (int h = 0; h < hold; h++) begin
                if (poke) begin
                    req_valid  = 1'b1;
                    req_pixels = ~pix;
                end
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_class !== o_cls || rsp_balance !== o_bal ||
                    rsp_error !== o_err || req_ready !== 1'b0 || net_start !== 1'b0 ||
                    net_pixels !== pix) begin
                    stab_err++;
                end
            end
        end
        req_valid  = 1'b0;
        rsp_ready  = 1'b1;
        clr_counts = clr;
        @(negedge clk);
        rsp_ready  = 1'b0;
        clr_counts = 1'b0;
    endtask

    // Shared observation variables for the test tasks.
    int               t_lat, t_starts, t_pix_err, t_stab_err;
    logic [1:0]       t_cls;
    logic [BAL_W-1:0] t_bal;
    logic             t_err, t_rdy_rise;
    bit               t_tmo;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        req_pixels = 2'b11;
        rsp_ready = 1'b0;
        clr_counts = 1'b0;
        net_neuron_out = 2'b01;
        net_balance = 3'd5;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({net_start, rsp_valid, rsp_error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl start/valid/error/busy got %b want 0000",
                     {net_start, rsp_valid, rsp_error, busy});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        checks++;
        if ({net_pixels, rsp_class, rsp_balance} !== '0) begin
            errors++;
            $display("FAIL reset_data pixels %b class %b bal %0d want 0",
                     net_pixels, rsp_class, rsp_balance);
        end
        checks++;
        if (pos_count !== '0 || neg_count !== '0) begin
            errors++;
            $display("FAIL reset_counts pos %0d neg %0d want 0", pos_count, neg_count);
        end
        m_pos = 0;
        m_neg = 0;
    endtask

    // Common comparison set for one completed transaction.
    task automatic test_single(input string name, input logic [HEIGHT-1:0] pix,
                               input logic [1:0] code, input logic [BAL_W-1:0] bal,
                               input int hold, input bit clr, input bit poke);
        run_txn(pix, code, bal, hold, clr, poke, t_lat, t_starts, t_pix_err, t_stab_err,
                t_cls, t_bal, t_err, t_rdy_rise, t_tmo);
        checks++;
        if (t_tmo || t_lat != EXP_LAT) begin
            errors++;
            $display("FAIL %s latency got %0d (timeout %0d) want %0d", name, t_lat, t_tmo, EXP_LAT);
        end
        checks++;
        if (t_starts != START_CYCLES || t_pix_err != 0) begin
            errors++;
            $display("FAIL %s net_start cycles %0d want %0d, pixel errors %0d want 0",
                     name, t_starts, START_CYCLES, t_pix_err);
        end
        checks++;
        if (t_cls !== exp_class(code) || t_err !== exp_error(code) || t_bal !== bal) begin
            errors++;
            $display("FAIL %s result class %b err %b bal %0d want class %b err %b bal %0d",
                     name, t_cls, t_err, t_bal, exp_class(code), exp_error(code), bal);
        end
        checks++;
        if (t_rdy_rise !== 1'b0 || t_stab_err != 0) begin
            errors++;
            $display("FAIL %s hold req_ready at rise %b, unstable cycles %0d want 0/0",
                     name, t_rdy_rise, t_stab_err);
        end
        model_accept(code, clr);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_accept valid %b ready %b busy %b want 0 1 0",
                     name, rsp_valid, req_ready, busy);
        end
        checks++;
        if (int'(pos_count) != m_pos || int'(neg_count) != m_neg) begin
            errors++;
            $display("FAIL %s tallies pos %0d neg %0d want %0d %0d",
                     name, pos_count, neg_count, m_pos, m_neg);
        end
    endtask

    task automatic test_pos();
        test_single("pos", 2'b11, 2'b01, 3'd3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_neg();
        test_single("neg", 2'b00, 2'b10, 3'd6, 1, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        test_single("error11", 2'b10, 2'b11, 3'd2, 0, 1'b0, 1'b0);
        test_single("error00", 2'b01, 2'b00, 3'd7, 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure();
        bit started;
        test_single("hold20", 2'b01, 2'b01, 3'd4, 20, 1'b0, 1'b1);
        // The request poked during the response must not have been queued.
        started = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (net_start || busy) started = 1'b1;
        end
        checks++;
        if (started) begin
            errors++;
            $display("FAIL hold20 queued_request started %b want 0", started);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [HEIGHT-1:0] pix;
            logic [1:0]        code;
            logic [BAL_W-1:0]  bal;
            pix  = HEIGHT'($urandom_range(0, 3));
            code = 2'($urandom_range(0, 3));
            bal  = BAL_W'($urandom_range(0, 7));
            test_single($sformatf("rand%0d", n), pix, code, bal,
                        int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), 1'b0);
        end
    endtask

    task automatic test_saturation();
        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        m_pos = 0;
        m_neg = 0;
        checks++;
        if (pos_count !== '0 || neg_count !== '0) begin
            errors++;
            $display("FAIL clr_idle pos %0d neg %0d want 0 0", pos_count, neg_count);
        end
        for (int n = 0; n < 4; n++) begin
            test_single($sformatf("sat%0d", n), 2'b11, 2'b01, 3'd1,
                        int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        checks++;
        if (int'(pos_count) != CNT_MAX) begin
            errors++;
            $display("FAIL saturate pos %0d want %0d", pos_count, CNT_MAX);
        end
        test_single("clr_with_accept", 2'b11, 2'b01, 3'd1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        net_neuron_out = 2'b01;
        net_balance    = 3'd5;
        req_valid  = 1'b1;
        req_pixels = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (START_CYCLES + 10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pos = 0;
        m_neg = 0;
        checks++;
        if (busy !== 1'b0 || net_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset busy %b start %b valid %b ready %b want 0 0 0 1",
                     busy, net_start, rsp_valid, req_ready);
        end
        checks++;
        if (net_pixels !== '0 || pos_count !== '0 || neg_count !== '0) begin
            errors++;
            $display("FAIL midrun_reset_data pixels %b pos %0d neg %0d want 0",
                     net_pixels, pos_count, neg_count);
        end
        seen = 1'b0;
        repeat (EXP_LAT + 20) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_discard response_or_busy_seen %b want 0", seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_pixels = '0;
        rsp_ready = 1'b0;
        clr_counts = 1'b0;
        net_neuron_out = '0;
        net_balance = '0;
        @(negedge clk);
        test_reset();
        test_pos();
        test_neg();
        test_error();
        test_back_pressure();
        test_random();
        test_saturation();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
